// File: rtl/npu_conv_stream_engine.sv
// Streaming K x K convolution engine: column-fed window sequencer, NUM_PE parallel channels,
// two-stage MAC pipeline with ReLU/saturation and a valid/ready result port with backpressure.
module npu_conv_stream_engine #(
    parameter int K      = 3,
    parameter int IN_H   = 16,
    parameter int IN_W   = 15,
    parameter int DW     = 8,
    parameter int WW     = 8,
    parameter int NUM_PE = 4,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    cfg_reuse_w,
    input  logic                    cfg_signed,
    input  logic                    cfg_relu,
    input  logic                    w_valid,
    input  logic [WW-1:0]           w_data,
    output logic                    w_ready,
    input  logic                    col_valid,
    input  logic [K*DW-1:0]         col_data,
    output logic                    col_ready,
    output logic                    out_valid,
    output logic [NUM_PE*OUT_W-1:0] out_data,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);
    localparam int OUT_H = IN_H - K + 1;
    localparam int KK    = K * K;
    localparam int NW    = NUM_PE * KK;
    localparam int PW    = DW + WW + 1;
    localparam int CW    = $clog2(IN_W);
    localparam int BW    = $clog2(OUT_H);
    localparam int IW    = $clog2(NW);

    localparam logic [CW-1:0] COL_LAST      = CW'(IN_W - 1);
    localparam logic [CW-1:0] COL_FIRST_OUT = CW'(K - 1);
    localparam logic [BW-1:0] BAND_LAST     = BW'(OUT_H - 1);
    localparam logic [IW-1:0] W_LAST        = IW'(NW - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WLOAD = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic                    cfg_signed_r, cfg_relu_r;
    logic [IW-1:0]           w_idx_r;
    logic [WW-1:0]           weight_r [NW];
    logic [CW-1:0]           col_cnt_r;
    logic [BW-1:0]           band_cnt_r;
    logic [DW-1:0]           win_r [K][K];
    logic                    win_valid_r, win_last_r;
    logic signed [PW-1:0]    prod_r [NW];
    logic signed [PW-1:0]    prod_s [NW];
    logic                    s1_valid_r, s1_last_r;
    logic                    out_valid_r, out_last_r, done_r;
    logic [NUM_PE*OUT_W-1:0] out_data_r, res_s;
    logic                    stall_s, col_accept_s, w_accept_s, last_col_s, pipe_empty_s, done_set_s;

    // Pixel x weight with the pixel sign- or zero-extended to DW+1 bits
    function automatic logic signed [PW-1:0] mul_px(input logic [DW-1:0] px, input logic [WW-1:0] w,
                                                    input logic sgn);
        logic signed [PW-1:0] a;
        logic signed [PW-1:0] b;
        a = {{(PW-DW){sgn & px[DW-1]}}, px};
        b = {{(PW-WW){w[WW-1]}}, w};
        return a * b;
    endfunction

    function automatic logic [OUT_W-1:0] relu_sat(input logic signed [ACC_W-1:0] s, input logic relu);
        logic [OUT_W-1:0] r;
        if (relu && s[ACC_W-1]) begin
            r = {OUT_W{1'b0}};
        end else if (s > SAT_MAX) begin
            r = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (s < SAT_MIN) begin
            r = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            r = s[OUT_W-1:0];
        end
        return r;
    endfunction

    assign stall_s      = out_valid_r & ~out_ready;
    assign col_ready    = (state_r == S_RUN) & ~stall_s;
    assign w_ready      = (state_r == S_WLOAD);
    assign busy         = (state_r != S_IDLE);
    assign col_accept_s = col_valid & col_ready;
    assign w_accept_s   = w_valid & w_ready;
    assign last_col_s   = (col_cnt_r == COL_LAST) && (band_cnt_r == BAND_LAST);
    assign pipe_empty_s = ~win_valid_r & ~s1_valid_r & ~out_valid_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_last     = out_last_r;
    assign done         = done_r;

    genvar gp, gr, gc;
    for (gp = 0; gp < NUM_PE; gp++) begin : g_pe
        logic signed [ACC_W-1:0] sum_s;
        for (gr = 0; gr < K; gr++) begin : g_row
            for (gc = 0; gc < K; gc++) begin : g_col
                assign prod_s[gp*KK + gr*K + gc] =
                    mul_px(win_r[gr][gc], weight_r[gp*KK + gr*K + gc], cfg_signed_r);
            end
        end
        // Adder tree over this channel's registered products, wrapping in ACC_W bits
        always_comb begin
            sum_s = {ACC_W{1'b0}};
            for (int i = 0; i < KK; i++) begin
                sum_s = sum_s + {{(ACC_W-PW){prod_r[gp*KK + i][PW-1]}}, prod_r[gp*KK + i]};
            end
        end
        assign res_s[gp*OUT_W +: OUT_W] = relu_sat(sum_s, cfg_relu_r);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and end-of-image detection
    always_comb begin
        state_s    = state_r;
        done_set_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = cfg_reuse_w ? S_RUN : S_WLOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WLOAD: begin
                if (w_accept_s && (w_idx_r == W_LAST)) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_WLOAD;
                end
            end
            S_RUN: begin
                if (col_accept_s && last_col_s) begin
                    state_s = S_FLUSH;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_FLUSH: begin
                if (pipe_empty_s) begin
                    state_s    = S_IDLE;
                    done_set_s = 1'b1;
                end else begin
                    state_s = S_FLUSH;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Weight store: written in load order, contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (w_accept_s) begin
            weight_r[w_idx_r] <= w_data;
        end
    end

    // Config, counters, window and MAC pipeline; a stall freezes every stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_signed_r <= 1'b0;
            cfg_relu_r   <= 1'b0;
            w_idx_r      <= {IW{1'b0}};
            col_cnt_r    <= {CW{1'b0}};
            band_cnt_r   <= {BW{1'b0}};
            win_valid_r  <= 1'b0;
            win_last_r   <= 1'b0;
            s1_valid_r   <= 1'b0;
            s1_last_r    <= 1'b0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_data_r   <= {(NUM_PE*OUT_W){1'b0}};
            done_r       <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_r[r][c] <= {DW{1'b0}};
                end
            end
            for (int i = 0; i < NW; i++) begin
                prod_r[i] <= {PW{1'b0}};
            end
        end else begin
            if ((state_r == S_IDLE) && start) begin
                cfg_signed_r <= cfg_signed;
                cfg_relu_r   <= cfg_relu;
                w_idx_r      <= {IW{1'b0}};
                col_cnt_r    <= {CW{1'b0}};
                band_cnt_r   <= {BW{1'b0}};
            end
            if (w_accept_s) begin
                w_idx_r <= (w_idx_r == W_LAST) ? {IW{1'b0}} : w_idx_r + IW'(1);
            end
            if (col_accept_s) begin
                if (last_col_s) begin
                    col_cnt_r  <= {CW{1'b0}};
                    band_cnt_r <= {BW{1'b0}};
                end else if (col_cnt_r == COL_LAST) begin
                    col_cnt_r  <= {CW{1'b0}};
                    band_cnt_r <= band_cnt_r + BW'(1);
                end else begin
                    col_cnt_r <= col_cnt_r + CW'(1);
                end
                // The first column of a band flushes the previous band's columns
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win_r[r][c] <= (col_cnt_r == {CW{1'b0}}) ? {DW{1'b0}} : win_r[r][c+1];
                    end
                    win_r[r][K-1] <= col_data[r*DW +: DW];
                end
            end
            if (!stall_s) begin
                win_valid_r <= col_accept_s && (col_cnt_r >= COL_FIRST_OUT);
                win_last_r  <= col_accept_s && last_col_s;
                prod_r      <= prod_s;
                s1_valid_r  <= win_valid_r;
                s1_last_r   <= win_last_r;
                out_valid_r <= s1_valid_r;
                out_last_r  <= s1_last_r;
                out_data_r  <= res_s;
            end
            done_r <= done_set_s;
        end
    end

endmodule

// File: tb/tb_npu_conv_stream_engine.sv
// Randomised bench for npu_conv_stream_engine: a plain-arithmetic convolution model fills an
// expected-result queue that one negedge process compares against every accepted output.
module tb_npu_conv_stream_engine;
    localparam int K = 3, IN_H = 16, IN_W = 15, DW = 8, WW = 8, NUM_PE = 4, ACC_W = 24, OUT_W = 16;
    localparam int OUT_H = IN_H - K + 1;
    localparam int OUT_PW = IN_W - K + 1;
    localparam int NOUT = OUT_H * OUT_PW;
    localparam int NW = NUM_PE * K * K;
    localparam int NCOL = OUT_H * IN_W;
    localparam int ODW = NUM_PE * OUT_W;

    logic clk, rst, start, cfg_reuse_w, cfg_signed, cfg_relu;
    logic w_valid, w_ready, col_valid, col_ready, out_valid, out_ready, out_last, busy, done;
    logic [WW-1:0] w_data;
    logic [K*DW-1:0] col_data;
    logic [ODW-1:0] out_data;

    npu_conv_stream_engine #(.K(K), .IN_H(IN_H), .IN_W(IN_W), .DW(DW), .WW(WW), .NUM_PE(NUM_PE),
                             .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_reuse_w(cfg_reuse_w), .cfg_signed(cfg_signed),
        .cfg_relu(cfg_relu), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .col_valid(col_valid), .col_data(col_data), .col_ready(col_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int img [IN_H][IN_W];
    int wts [NW];
    logic [ODW-1:0] exp_d [$];
    bit exp_l [$];
    int tests = 0, fails = 0;
    int cyc = 0, out_cnt = 0, done_cnt = 0, last_hs = -100;
    bit chk_en = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [ODW-1:0] prev_data, first_out, exp_word;
    bit exp_last;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int px_val(input int v, input bit sgn);
        return (sgn && v >= 128) ? v - 256 : v;
    endfunction

    // Direct convolution over the whole image, in output order
    task automatic build_expected(input bit sgn, input bit relu);
        int s;
        logic signed [ACC_W-1:0] t;
        logic [ODW-1:0] word;
        exp_d.delete();
        exp_l.delete();
        for (int oy = 0; oy < OUT_H; oy++) begin
            for (int ox = 0; ox < OUT_PW; ox++) begin
                word = '0;
                for (int p = 0; p < NUM_PE; p++) begin
                    s = 0;
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            s += px_val(img[oy+r][ox+c], sgn) * wts[p*K*K + r*K + c];
                    t = s[ACC_W-1:0];
                    s = t;
                    if (relu && s < 0) s = 0;
                    if (s > 32767) s = 32767;
                    if (s < -32768) s = -32768;
                    word[p*OUT_W +: OUT_W] = s[OUT_W-1:0];
                end
                exp_d.push_back(word);
                exp_l.push_back(oy == OUT_H - 1 && ox == OUT_PW - 1);
            end
        end
    endtask

    // mode 0: constant v, 1: r*IN_W+c, 2: random
    task automatic fill_img(input int mode, input int v);
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++)
                img[r][c] = (mode == 0) ? v : (mode == 1) ? r * IN_W + c : int'($urandom_range(255));
    endtask

    // Output scoreboard, hold-under-stall and done-timing checks
    always @(negedge clk) begin
        if (chk_en) begin
            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    check("extra_output", 64'(out_cnt), 64'(NOUT));
                end else begin
                    exp_word = exp_d.pop_front();
                    exp_last = exp_l.pop_front();
                    check("out_data", out_data, exp_word);
                    check("out_last", 64'(out_last), 64'(exp_last));
                    if (out_cnt == 0) first_out = out_data;
                    out_cnt++;
                    if (exp_last) last_hs = cyc;
                end
            end
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", out_data, prev_data);
                check("hold_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && !out_ready) check("stall_col_ready", 64'(col_ready), 64'd0);
            if (done) begin
                check("done_timing", 64'(cyc), 64'(last_hs + 2));
                done_cnt++;
            end
        end
        prev_stall = chk_en && out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
        cyc++;
    end

    task automatic idle_inputs();
        start = 1'b0; w_valid = 1'b0; col_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic run_image(input bit reuse, input bit sgn, input bit relu, input int gap_pct,
                             input int rdy_pct, input int hold_at, input int abort_at);
        int wi, ci, n, tmp, band, cc, d0;
        bit wr_seen, fin;
        build_expected(sgn, relu);
        out_cnt = 0; last_hs = -100; d0 = done_cnt;
        wi = 0; ci = 0; n = 0; wr_seen = 1'b0; fin = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; cfg_reuse_w = reuse; cfg_signed = sgn; cfg_relu = relu;
        @(posedge clk); #1;
        while (!fin && n < 4000) begin
            start = (n == 50);
            cfg_reuse_w = $urandom_range(1); cfg_signed = $urandom_range(1); cfg_relu = $urandom_range(1);
            w_valid = !reuse && wi < NW && int'($urandom_range(99)) >= gap_pct;
            tmp = wts[(wi < NW) ? wi : 0];
            w_data = tmp[WW-1:0];
            col_valid = ci < NCOL && int'($urandom_range(99)) >= gap_pct;
            band = ci / IN_W; cc = ci % IN_W;
            for (int r = 0; r < K; r++) begin
                tmp = img[(band + r < IN_H) ? band + r : 0][cc];
                col_data[r*DW +: DW] = tmp[DW-1:0];
            end
            if (hold_at >= 0 && n >= hold_at && n < hold_at + 5) out_ready = 1'b0;
            else out_ready = int'($urandom_range(99)) < rdy_pct;
            @(negedge clk);
            if (w_ready) wr_seen = 1'b1;
            if (w_valid && w_ready) wi++;
            if (col_valid && col_ready) ci++;
            if (done) fin = 1'b1;
            if (n == abort_at) begin
                check("abort_pre_busy", 64'(busy), 64'd1);
                chk_en = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                idle_inputs();
                @(negedge clk);
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_out_valid", 64'(out_valid), 64'd0);
                check("abort_col_ready", 64'(col_ready), 64'd0);
                check("abort_done", 64'(done), 64'd0);
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                exp_d.delete(); exp_l.delete();
                @(negedge clk);
                chk_en = 1'b1;
                return;
            end
            @(posedge clk); #1;
            n++;
        end
        idle_inputs();
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        check("out_count", 64'(out_cnt), 64'(NOUT));
        check("queue_empty", 64'(exp_d.size()), 64'd0);
        if (reuse) check("w_ready_on_reuse", 64'(wr_seen), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cfg_reuse_w = 1'b0; cfg_signed = 1'b0; cfg_relu = 1'b0;
        w_data = '0; col_data = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_w_ready", 64'(w_ready), 64'd0);
        check("rst_col_ready", 64'(col_ready), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // All ones: every channel sums to 9
        fill_img(0, 1);
        for (int i = 0; i < NW; i++) wts[i] = 1;
        run_image(1'b0, 1'b0, 1'b0, 0, 100, -1, -1);
        check("t1_first", first_out, 64'h0009_0009_0009_0009);

        // Centre tap only, ramp image: channel p = (p+1)*pixel(r+1,c+1)
        fill_img(1, 0);
        for (int i = 0; i < NW; i++) wts[i] = (i % 9 == 4) ? i / 9 + 1 : 0;
        run_image(1'b0, 1'b0, 1'b0, 20, 80, -1, -1);
        check("t2_first", first_out, 64'h0040_0030_0020_0010);

        // 8'hFF pixels: signed -9, signed+ReLU 0, unsigned 2295
        fill_img(0, 255);
        for (int i = 0; i < NW; i++) wts[i] = 1;
        run_image(1'b0, 1'b1, 1'b0, 0, 100, -1, -1);
        check("t3_signed", first_out, 64'hFFF7_FFF7_FFF7_FFF7);
        run_image(1'b1, 1'b1, 1'b1, 0, 100, -1, -1);
        check("t3_relu", first_out, 64'h0000_0000_0000_0000);
        run_image(1'b1, 1'b0, 1'b0, 0, 100, -1, -1);
        check("t3_unsigned", first_out, 64'h08F7_08F7_08F7_08F7);

        // 255 * 127 * 9 = 291465 saturates
        for (int i = 0; i < NW; i++) wts[i] = 127;
        run_image(1'b0, 1'b0, 1'b0, 0, 100, -1, -1);
        check("t4_sat", first_out, 64'h7FFF_7FFF_7FFF_7FFF);

        // Random data with a 5-cycle out_ready hold mid-band, then a weight-reuse rerun
        fill_img(2, 0);
        for (int i = 0; i < NW; i++) wts[i] = int'($urandom_range(255)) - 128;
        run_image(1'b0, 1'b1, 1'b0, 0, 100, 100, -1);
        run_image(1'b1, 1'b1, 1'b0, 30, 60, -1, -1);

        // Random configurations and handshake pressure
        for (int t = 0; t < 4; t++) begin
            fill_img(2, 0);
            for (int i = 0; i < NW; i++) wts[i] = int'($urandom_range(255)) - 128;
            run_image(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                      int'($urandom_range(40)), 40 + int'($urandom_range(60)), -1, -1);
        end

        // Reset mid-band, then a fresh run with a weight reload
        run_image(1'b1, 1'b0, 1'b0, 0, 100, -1, 80);
        fill_img(2, 0);
        run_image(1'b0, 1'b0, 1'b1, 10, 70, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
